// File: rtl/ysyx_25040101_ifu_if.sv
// ysyx_25040101_ifu_if: fetch bus plus decode/execute handshake seen by the IFU
interface ysyx_25040101_ifu_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_ready;
    logic        npc_valid;
    logic [31:0] npc;
    logic [1:0]  err;
    modport master (
        output req_valid, req_addr, inst_valid, inst, pc, err,
        input  req_ready, resp_valid, resp_data, resp_err, inst_ready, npc_valid, npc
    );
    modport slave (
        input  req_valid, req_addr, inst_valid, inst, pc, err,
        output req_ready, resp_valid, resp_data, resp_err, inst_ready, npc_valid, npc
    );
endinterface

// File: rtl/ysyx_25040101_ifu.sv
// ysyx_25040101_ifu: single-beat instruction fetch with sticky error halt
module ysyx_25040101_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 8
) (
    input logic                  clk_i,
    input logic                  rst_n_i,
    ysyx_25040101_ifu_if.master  bus
);
    localparam logic [2:0] S_REQ  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_NPC  = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;
    logic [2:0]       state;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [1:0]       err;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;
    logic             npc_take;
    logic             npc_ok;
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign npc_take  = bus.npc_valid && ((state == S_NPC) || (state == S_HOLD && bus.inst_ready));
    assign npc_ok    = bus.npc[1:0] == 2'b00;
    // reset only qualifies the request so nothing is offered to memory while held in reset
    assign bus.req_valid  = rst_n_i && state == S_REQ;
    assign bus.req_addr   = pc;
    assign bus.inst_valid = state == S_HOLD;
    assign bus.inst       = inst;
    assign bus.pc         = pc;
    assign bus.err        = err;
    // fetch state machine; every error lands in HALT so err keeps its first code
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            inst  <= '0;
            err   <= 2'b00;
            cnt   <= '0;
        end else begin
            case (state)
                S_REQ: if (bus.req_ready) begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (bus.resp_valid && bus.resp_err) begin
                        err   <= 2'b01;
                        state <= S_HALT;
                    end else if (bus.resp_valid) begin
                        inst  <= bus.resp_data;
                        state <= S_HOLD;
                    end else if (timed_out) begin
                        err   <= 2'b11;
                        state <= S_HALT;
                    end
                end
                S_HOLD: if (bus.inst_ready && !bus.npc_valid) state <= S_NPC;
                default: ;
            endcase
            if (npc_take && npc_ok) begin
                pc    <= bus.npc;
                state <= S_REQ;
            end else if (npc_take) begin
                err   <= 2'b10;
                state <= S_HALT;
            end
        end
    end
endmodule
